// File: rtl/tx_lane_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_lane_scheduler_if
//   User-side handshake and lane-side slot outputs of tx_lane_scheduler.
//   master : the user / lane consumer (drives tx_valid, tx_data)
//   slave  : the scheduler (drives tx_ready and all slot outputs)
//   Signals:
//     tx_valid   user word available
//     tx_data    user word (16 bit)
//     tx_ready   word accepted this cycle when tx_valid & tx_ready
//     send_idle  registered idle slot request
//     send_cc    registered clock-compensation slot
//     send_data  registered data slot, lane_data valid
//     lane_data  registered accepted user word
//     cc_count   registered count of completed CC sequences (saturating)
// ---------------------------------------------------------------------------
interface tx_lane_scheduler_if;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        send_idle;
  logic        send_cc;
  logic        send_data;
  logic [15:0] lane_data;
  logic [15:0] cc_count;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, send_idle, send_cc, send_data, lane_data, cc_count
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, send_idle, send_cc, send_data, lane_data, cc_count
  );
endinterface

// File: rtl/tx_lane_scheduler.sv
// ---------------------------------------------------------------------------
// tx_lane_scheduler
//   Decides one transmit slot per cycle (idle, clock-compensation or user
//   data) and presents it registered one cycle later. A CC sequence of CC_LEN
//   consecutive slots starts every CC_PERIOD cycles while the channel is up;
//   user words are back-pressured with tx_ready during CC.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     channel_up  lane initialised; low forces idle and returns to DOWN
//     lane        tx_lane_scheduler_if.slave (handshake + slot outputs)
// ---------------------------------------------------------------------------
module tx_lane_scheduler #(
  parameter int unsigned CC_PERIOD = 5000,  // CC_LEN+2 .. 65535
  parameter int unsigned CC_LEN    = 6      // 1 .. 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 channel_up,
  tx_lane_scheduler_if.slave   lane
);

  localparam logic [1:0] ST_DOWN = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_CC   = 2'd2;

  localparam logic [15:0] CC_DUE_VAL = 16'(CC_PERIOD - 1);
  localparam logic [3:0]  CC_LEFT_LD = 4'(CC_LEN - 1);

  logic [1:0]  state;
  logic [15:0] cc_timer;
  logic [3:0]  cc_left;
  logic [15:0] cc_count_r;
  logic [15:0] lane_data_r;
  logic        send_idle_r;
  logic        send_cc_r;
  logic        send_data_r;

  logic cc_due;
  logic tx_ready_int;
  logic slot_idle;
  logic slot_cc;
  logic slot_data;
  logic seq_done;

  // The cc_due cycle is itself the first CC slot, so the handshake is closed
  // on it as well as in every CC-state cycle.
  assign cc_due       = !rst && channel_up && (state == ST_RUN) && (cc_timer == CC_DUE_VAL);
  assign tx_ready_int = !rst && channel_up && (state == ST_RUN) && !cc_due;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    slot_idle = 1'b1;
    slot_cc   = 1'b0;
    slot_data = 1'b0;
    if (!channel_up || state == ST_DOWN) begin
      slot_idle = 1'b1;
    end else if (state == ST_CC || cc_due) begin
      slot_idle = 1'b0;
      slot_cc   = 1'b1;
    end else if (lane.tx_valid && tx_ready_int) begin
      slot_idle = 1'b0;
      slot_data = 1'b1;
    end
  end

  // Last slot of a sequence: the final CC-state cycle, or the cc_due cycle
  // alone when the sequence is a single slot long.
  assign seq_done = slot_cc &&
                    ((state == ST_CC && cc_left == 4'd1) || (cc_due && CC_LEN == 1));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_DOWN;
      cc_timer    <= 16'd0;
      cc_left     <= 4'd0;
      cc_count_r  <= 16'd0;
      lane_data_r <= 16'd0;
      send_idle_r <= 1'b0;
      send_cc_r   <= 1'b0;
      send_data_r <= 1'b0;
    end else begin
      send_idle_r <= slot_idle;
      send_cc_r   <= slot_cc;
      send_data_r <= slot_data;
      if (slot_data) begin
        lane_data_r <= lane.tx_data;
      end
      if (seq_done && cc_count_r != 16'hFFFF) begin
        cc_count_r <= cc_count_r + 16'd1;
      end

      if (!channel_up) begin
        // Aborts any CC in progress; it is not counted since seq_done
        // requires channel_up through slot_cc.
        state    <= ST_DOWN;
        cc_timer <= 16'd0;
        cc_left  <= 4'd0;
      end else begin
        case (state)
          ST_DOWN: begin
            state    <= ST_RUN;
            cc_timer <= 16'd0;
          end
          ST_RUN: begin
            if (cc_due) begin
              cc_timer <= 16'd0;
              if (CC_LEN > 1) begin
                state   <= ST_CC;
                cc_left <= CC_LEFT_LD;
              end
            end else begin
              cc_timer <= cc_timer + 16'd1;
            end
          end
          ST_CC: begin
            // CC_PERIOD >= CC_LEN+2 keeps the timer clear of the wrap value here.
            cc_timer <= cc_timer + 16'd1;
            cc_left  <= cc_left - 4'd1;
            if (cc_left == 4'd1) begin
              state <= ST_RUN;
            end
          end
          default: begin
            state    <= ST_DOWN;
            cc_timer <= 16'd0;
            cc_left  <= 4'd0;
          end
        endcase
      end
    end
  end

  assign lane.tx_ready  = tx_ready_int;
  assign lane.send_idle = send_idle_r;
  assign lane.send_cc   = send_cc_r;
  assign lane.send_data = send_data_r;
  assign lane.lane_data = lane_data_r;
  assign lane.cc_count  = cc_count_r;

endmodule

// File: doc/tx_lane_scheduler.md
TX_LANE_SCHEDULER -- requirements
Module: tx_lane_scheduler

Interface
REQ-001 SHALL have parameter CC_PERIOD, default 5000: cycles between starts of successive clock-compensation (CC) sequences; legal range CC_LEN+2..65535.
REQ-002 SHALL have parameter CC_LEN, default 6: number of consecutive CC slots per sequence; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port channel_up, input, 1: lane/channel initialised; 0 forces idle.
REQ-006 SHALL have port tx_valid, input, 1: user word available.
REQ-007 SHALL have port tx_data, input, 16: user word.
REQ-008 SHALL have port tx_ready, output, 1: combinational; user word is accepted this cycle when tx_valid and tx_ready are both 1.
REQ-009 SHALL have port send_idle, output, 1: registered; idle generator request for this slot.
REQ-010 SHALL have port send_cc, output, 1: registered; CC character slot.
REQ-011 SHALL have port send_data, output, 1: registered; lane_data is valid this slot.
REQ-012 SHALL have port lane_data, output, 16: registered; accepted user word.
REQ-013 SHALL have port cc_count, output, 16: registered; number of completed CC sequences.

Function
REQ-014 SHALL implement states DOWN, RUN and CC, plus a 16-bit cc_timer and a 4-bit cc_left counter.
REQ-015 SHALL decide one slot per cycle t and present it on send_idle/send_cc/send_data/lane_data at t+1 (latency 1).
REQ-016 SHALL assert cc_due = (state==RUN) & channel_up & (cc_timer==CC_PERIOD-1).
REQ-017 SHALL apply slot priority, highest first: !channel_up or DOWN -> idle; state CC or cc_due -> cc; tx_valid & tx_ready -> data; otherwise -> idle.
REQ-018 SHALL drive tx_ready = channel_up & (state==RUN) & !cc_due; it is never asserted in DOWN or CC.
REQ-019 SHALL, after reset, assert exactly one of send_idle, send_cc and send_data every cycle.
REQ-020 SHALL load lane_data with tx_data on a data slot and hold its previous value otherwise.
REQ-021 SHALL hold cc_timer at 0 in DOWN, and SHALL move DOWN -> RUN on the cycle after channel_up=1 is sampled; the first RUN cycle has cc_timer=0.
REQ-022 SHALL increment cc_timer every cycle in RUN and CC, and wrap it to 0 on the cc_due cycle, so CC sequences start every CC_PERIOD cycles.
REQ-023 SHALL treat the cc_due cycle as CC slot 1: it moves RUN -> CC and loads cc_left=CC_LEN-1; if CC_LEN=1, it stays in RUN and counts completion immediately.
REQ-024 SHALL issue a cc slot and decrement cc_left on each CC cycle; when cc_left==1 the state SHALL return to RUN, giving exactly CC_LEN consecutive cc slots.
REQ-025 SHALL increment cc_count by 1 on the last slot of each complete CC sequence, saturating at 0xFFFF.
REQ-026 SHALL, when channel_up=0 in any state, force an idle slot that cycle and enter DOWN next cycle; any CC in progress is aborted, is not counted, and cc_timer and cc_left clear to 0.
REQ-027 SHALL resume user data on the cycle after the final CC slot; tx_valid held through a CC is accepted once tx_ready returns, with no word lost or duplicated.

Reset
REQ-028 SHALL, while rst=1, force state DOWN, cc_timer=0, cc_left=0, cc_count=0, lane_data=0, and send_idle=send_cc=send_data=0.
REQ-029 SHALL hold tx_ready=0 during reset; rst mid-CC aborts the sequence with no count.
REQ-030 SHALL present the first slot decision in the cycle after rst is released, starting from DOWN.

Verification (CC_PERIOD=16, CC_LEN=4)
REQ-031 SHALL cover: rst released at cycle 0, channel_up=1, tx_valid=0 -> send_idle at cycles 1-16, send_cc at 17-20, idle resumes at 21, cc_count=1 at cycle 21.
REQ-032 SHALL cover: tx_valid=1 with incrementing tx_data from 0x0000 starting cycle 1 -> send_data with 0x0000.. from cycle 2; tx_ready=0 at cycles 16-19; words resume at 0x000F with no gap or duplicate.
REQ-033 SHALL cover: channel_up dropped at cycle 18, mid-CC -> idle slot at cycle 19, state DOWN, cc_count stays 0, tx_ready=0; re-raising channel_up restarts cc_timer from 0.
REQ-034 SHALL cover: rst pulsed for 1 cycle during data flow -> all outputs 0 the next cycle, cc_count=0, then idle slots until RUN.
REQ-035 SHALL cover: 0x10000+ completed sequences (forced counter) -> cc_count saturates at 0xFFFF.
REQ-036 SHALL cover: CC_LEN=1 build -> single send_cc slot every 16 cycles, tx_ready low only on the cc_due cycle.
